blit_coordgen: RTL
==================

Name: blit_coordgen

Overview:
Command-side pixel sequencer for the blitter. It accepts one rectangle or line command and walks it one pixel per un-stalled cycle. Each pixel is driven onto the p2_* coordinate bus that feeds the blitter address generator stage, under the same shared stall. It is the producer end of that coordinate interface: rectangle raster scan plus Bresenham line stepping.

Parameters:
COORD_W, 16, width of all coordinate and size fields

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
stall  in  1  pipeline stall shared with the downstream stage; freezes all p2_* outputs and state
cmd_valid  in  1  command offered
cmd_ready  out  1  high in IDLE only
cmd_is_line  in  1  1 = line command, 0 = rectangle command
cmd_dest_x  in  16  rectangle top-left x, or line start x0
cmd_dest_y  in  16  rectangle top-left y, or line start y0
cmd_src_x  in  16  rectangle source x (pixel or bit units; pass-through meaning)
cmd_src_y  in  16  rectangle source y
cmd_width  in  16  rectangle width in pixels
cmd_height  in  16  rectangle height in pixels
cmd_end_x  in  16  line end x1
cmd_end_y  in  16  line end y1
p2_rect_dest_x  out  16  current rectangle destination x
p2_rect_dest_y  out  16  current rectangle destination y
p2_rect_src_x  out  16  current rectangle source x
p2_rect_src_y  out  16  current rectangle source y
p2_line_x  out  16  current line x
p2_line_y  out  16  current line y
p2_run_rect  out  1  valid rectangle pixel this cycle
p2_run_line  out  1  valid line pixel this cycle
busy  out  1  command in progress (RECT or LINE state)
done  out  1  one-cycle pulse after the final pixel is issued

Behaviour:
- Reset (asynchronous, reset_n low):
  - state = IDLE.
  - All p2_* coordinates = 0; p2_run_rect = p2_run_line = 0.
  - busy = 0; done = 0; cmd_ready = 1.
- stall high: state, counters and all outputs hold, except cmd_ready, which is combinational from state. No command is accepted while stalled.
- States: IDLE, RECT, LINE.
- IDLE:
  - Accept when cmd_valid && cmd_ready && !stall.
  - Rectangle with width==0 or height==0: issue no pixel, pulse done next cycle, stay in IDLE.
  - Otherwise enter RECT or LINE.
  - The first pixel appears on p2_* the cycle after acceptance (latency 1).
- RECT, raster order with x inner and y outer:
  - Pixel (i,j): dest = (dest_x+i, dest_y+j), src = (src_x+i, src_y+j), for i in 0..width-1 and j in 0..height-1.
  - All sums are modulo 2^16.
  - p2_run_rect = 1 for exactly width*height un-stalled cycles.
- LINE, Bresenham:
  - dx = |x1-x0|, dy = -|y1-y0|, err = dx+dy, held in 18-bit signed.
  - sx/sy = +1 or -1 from the sign of the 16-bit wrapped difference.
  - Emit (x,y), then: e2 = 2*err; if e2>=dy then err+=dy, x+=sx; if e2<=dx then err+=dx, y+=sy.
  - Endpoints are inclusive. x0==x1 and y0==y1 emits exactly one pixel.
  - p2_run_line = 1 per emitted pixel.
- The final pixel is detected in the same cycle it is driven:
  - RECT: i==width-1 && j==height-1.
  - LINE: x==x1 && y==y1.
  - On the next un-stalled cycle: run flags drop, done pulses for 1 cycle, state returns to IDLE.
- Back-to-back commands: cmd_ready rises with done. A new command accepted in that cycle produces its first pixel on the following cycle. There is therefore a single-cycle bubble between commands.
- Unused bus: p2_line_* hold their last value during RECT; p2_rect_* hold during LINE. Downstream muxes on p2_run_line.
- Clipping is performed downstream; this block emits off-screen and negative coordinates unchanged.

Optional Feature:
BLIT_RECT_REVERSE_EN
- Defined:
  - Adds input port cmd_reverse (1 bit), sampled at acceptance.
  - When set, RECT walks from (width-1, height-1) down to (0,0), x inner, for overlapping copies where dest is after src.
  - Final-pixel detection becomes i==0 && j==0.
- Undefined: the port is absent and the walk is always forward.

Decomposition:
- Package blit_pkg holds:
  - the state enum (IDLE, RECT, LINE);
  - COORD_W;
  - the Bresenham error width (COORD_W+2).
- One natural sub-module: blit_line_step, a combinational Bresenham next-x/y/err calculator, reusable by a future line-drawing feature.

Test Plan:
- Rectangle dest(10,20), src(3,4), width=3, height=2, no stall -> exactly 6 pixels, one per cycle, 1 cycle after acceptance:
  - dest (10,20),(11,20),(12,20),(10,21),(11,21),(12,21);
  - src x tracks 3..5 on each row;
  - then done for 1 cycle.
- Line (0,0)->(5,2) -> 6 pixels (0,0),(1,0),(2,1),(3,1),(4,2),(5,2). Line (5,5)->(5,5) -> 1 pixel, then done.
- Line (3,3)->(0,0), negative direction -> (3,3),(2,2),(1,1),(0,0).
- Stall asserted for 3 cycles mid-rectangle at pixel (11,20) -> outputs frozen at (11,20) with run held high; no pixel skipped or duplicated; total run cycles still 6.
- width=0 command -> zero run cycles, done 1 cycle after acceptance, cmd_ready stays 1. Assert reset_n low mid-line -> all outputs 0 and state IDLE immediately, without waiting for a clock edge.
- With BLIT_RECT_REVERSE_EN and cmd_reverse=1, 2x2 at (0,0) -> pixel order (1,1),(0,1),(1,0),(0,0).

Source files
------------

// File: rtl/blit_pkg.sv
// Shared types for the blitter coordinate sequencer.
// Optional rectangle reverse walk: BLIT_RECT_REVERSE_EN.
package blit_pkg;

  localparam int COORD_W = 16;
  localparam int ERR_W   = COORD_W + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECT = 2'd1,
    LINE = 2'd2
  } blit_state_e;

endpackage

// File: rtl/blit_coordgen_if.sv
// Command handshake into the blitter coordinate sequencer.
// cmd_reverse exists only with BLIT_RECT_REVERSE_EN.
interface blit_coordgen_if #(
   parameter int COORD_W = 16
);

   logic               cmd_valid;
   logic               cmd_ready;
   logic               cmd_is_line;
   logic [COORD_W-1:0] cmd_dest_x;
   logic [COORD_W-1:0] cmd_dest_y;
   logic [COORD_W-1:0] cmd_src_x;
   logic [COORD_W-1:0] cmd_src_y;
   logic [COORD_W-1:0] cmd_width;
   logic [COORD_W-1:0] cmd_height;
   logic [COORD_W-1:0] cmd_end_x;
   logic [COORD_W-1:0] cmd_end_y;
`ifdef BLIT_RECT_REVERSE_EN
   logic               cmd_reverse;
`endif

   modport master (
      output cmd_valid, cmd_is_line,
      output cmd_dest_x, cmd_dest_y,
      output cmd_src_x, cmd_src_y,
      output cmd_width, cmd_height,
      output cmd_end_x, cmd_end_y,
`ifdef BLIT_RECT_REVERSE_EN
      output cmd_reverse,
`endif
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_is_line,
      input  cmd_dest_x, cmd_dest_y,
      input  cmd_src_x, cmd_src_y,
      input  cmd_width, cmd_height,
      input  cmd_end_x, cmd_end_y,
`ifdef BLIT_RECT_REVERSE_EN
      input  cmd_reverse,
`endif
      output cmd_ready
   );

endinterface

// File: rtl/blit_line_step.sv
// Combinational Bresenham step: next x/y/err from the current point.
module blit_line_step #(
   parameter int W  = 16,
   parameter int EW = W + 2
) (
   input  logic [W-1:0]         x,
   input  logic [W-1:0]         y,
   input  logic signed [EW-1:0] err,
   input  logic signed [EW-1:0] dx,
   input  logic signed [EW-1:0] dy,
   input  logic                 sx_neg,
   input  logic                 sy_neg,
   output logic [W-1:0]         nx,
   output logic [W-1:0]         ny,
   output logic signed [EW-1:0] nerr
);

   logic signed [EW:0] e2;
   logic signed [EW:0] dx_w;
   logic signed [EW:0] dy_w;
   logic               step_x;
   logic               step_y;

   always_comb begin
      e2     = {err, 1'b0};
      dx_w   = {dx[EW-1], dx};
      dy_w   = {dy[EW-1], dy};
      step_x = (e2 >= dy_w);
      step_y = (e2 <= dx_w);
      nerr   = err;
      if (step_x) nerr = nerr + dy;
      if (step_y) nerr = nerr + dx;
      nx = x;
      ny = y;
      if (step_x) nx = sx_neg ? x - W'(1) : x + W'(1);
      if (step_y) ny = sy_neg ? y - W'(1) : y + W'(1);
   end

endmodule

// File: rtl/blit_coordgen.sv
// Blitter pixel sequencer: rectangle raster scan and Bresenham lines.
// BLIT_RECT_REVERSE_EN adds a reverse rectangle walk (cmd_reverse).
module blit_coordgen #(
   parameter int COORD_W = 16
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               stall,
   blit_coordgen_if.slave     cmd,
   output logic [COORD_W-1:0] p2_rect_dest_x,
   output logic [COORD_W-1:0] p2_rect_dest_y,
   output logic [COORD_W-1:0] p2_rect_src_x,
   output logic [COORD_W-1:0] p2_rect_src_y,
   output logic [COORD_W-1:0] p2_line_x,
   output logic [COORD_W-1:0] p2_line_y,
   output logic               p2_run_rect,
   output logic               p2_run_line,
   output logic               busy,
   output logic               done
);

   import blit_pkg::*;

   localparam int EW = COORD_W + 2;
   localparam logic [COORD_W-1:0] ONE = COORD_W'(1);

   blit_state_e state;

   logic [COORD_W-1:0] base_dx, base_dy;
   logic [COORD_W-1:0] base_sx, base_sy;
   logic [COORD_W-1:0] w_m1, h_m1;
   logic [COORD_W-1:0] ri, rj, ni, nj;
   logic [COORD_W-1:0] i0, j0;
   logic [COORD_W-1:0] end_x, end_y;
   logic [COORD_W-1:0] diff_x, diff_y;
   logic [COORD_W-1:0] mag_x, mag_y;
   logic [COORD_W-1:0] nx, ny;
   logic signed [EW-1:0] err, ldx, ldy;
   logic signed [EW-1:0] dx0, dy0, nerr;
   logic sx_neg, sy_neg;
   logic rev_q, rev_in;
   logic zero_sz, i_end, r_last, l_last;

`ifdef BLIT_RECT_REVERSE_EN
   assign rev_in = cmd.cmd_reverse;
`else
   assign rev_in = 1'b0;
`endif

   assign cmd.cmd_ready = (state == IDLE);

   // Direction comes from the wrapped 16-bit difference
   assign diff_x  = cmd.cmd_end_x - cmd.cmd_dest_x;
   assign diff_y  = cmd.cmd_end_y - cmd.cmd_dest_y;
   assign mag_x   = diff_x[COORD_W-1] ? -diff_x : diff_x;
   assign mag_y   = diff_y[COORD_W-1] ? -diff_y : diff_y;
   assign dx0     = $signed({2'b00, mag_x});
   assign dy0     = -$signed({2'b00, mag_y});
   assign zero_sz = (cmd.cmd_width == '0) ||
                    (cmd.cmd_height == '0);
   assign i0      = rev_in ? cmd.cmd_width - ONE : '0;
   assign j0      = rev_in ? cmd.cmd_height - ONE : '0;
   assign l_last  = (p2_line_x == end_x) &&
                    (p2_line_y == end_y);

   always_comb begin
      i_end  = rev_q ? (ri == '0) : (ri == w_m1);
      r_last = i_end && (rev_q ? (rj == '0) : (rj == h_m1));
      ni     = rev_q ? ri - ONE : ri + ONE;
      nj     = rj;
      if (i_end) begin
         ni = rev_q ? w_m1 : '0;
         nj = rev_q ? rj - ONE : rj + ONE;
      end
   end

   blit_line_step #(
      .W  (COORD_W),
      .EW (EW)
   ) u_step (
      .x      (p2_line_x),
      .y      (p2_line_y),
      .err    (err),
      .dx     (ldx),
      .dy     (ldy),
      .sx_neg (sx_neg),
      .sy_neg (sy_neg),
      .nx     (nx),
      .ny     (ny),
      .nerr   (nerr)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         p2_rect_dest_x <= '0;
         p2_rect_dest_y <= '0;
         p2_rect_src_x  <= '0;
         p2_rect_src_y  <= '0;
         p2_line_x      <= '0;
         p2_line_y      <= '0;
         p2_run_rect    <= 1'b0;
         p2_run_line    <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         base_dx        <= '0;
         base_dy        <= '0;
         base_sx        <= '0;
         base_sy        <= '0;
         w_m1           <= '0;
         h_m1           <= '0;
         ri             <= '0;
         rj             <= '0;
         end_x          <= '0;
         end_y          <= '0;
         err            <= '0;
         ldx            <= '0;
         ldy            <= '0;
         sx_neg         <= 1'b0;
         sy_neg         <= 1'b0;
         rev_q          <= 1'b0;
      end else if (!stall) begin
         unique case (state)
            IDLE: begin
               done <= 1'b0;
               if (cmd.cmd_valid) begin
                  if (cmd.cmd_is_line) begin
                     state       <= LINE;
                     busy        <= 1'b1;
                     p2_run_line <= 1'b1;
                     p2_line_x   <= cmd.cmd_dest_x;
                     p2_line_y   <= cmd.cmd_dest_y;
                     end_x       <= cmd.cmd_end_x;
                     end_y       <= cmd.cmd_end_y;
                     ldx         <= dx0;
                     ldy         <= dy0;
                     err         <= dx0 + dy0;
                     sx_neg      <= diff_x[COORD_W-1];
                     sy_neg      <= diff_y[COORD_W-1];
                  end else if (zero_sz) begin
                     done <= 1'b1;
                  end else begin
                     state          <= RECT;
                     busy           <= 1'b1;
                     p2_run_rect    <= 1'b1;
                     base_dx        <= cmd.cmd_dest_x;
                     base_dy        <= cmd.cmd_dest_y;
                     base_sx        <= cmd.cmd_src_x;
                     base_sy        <= cmd.cmd_src_y;
                     w_m1           <= cmd.cmd_width - ONE;
                     h_m1           <= cmd.cmd_height - ONE;
                     rev_q          <= rev_in;
                     ri             <= i0;
                     rj             <= j0;
                     p2_rect_dest_x <= cmd.cmd_dest_x + i0;
                     p2_rect_dest_y <= cmd.cmd_dest_y + j0;
                     p2_rect_src_x  <= cmd.cmd_src_x + i0;
                     p2_rect_src_y  <= cmd.cmd_src_y + j0;
                  end
               end
            end
            RECT: begin
               if (r_last) begin
                  state       <= IDLE;
                  busy        <= 1'b0;
                  p2_run_rect <= 1'b0;
                  done        <= 1'b1;
               end else begin
                  ri             <= ni;
                  rj             <= nj;
                  p2_rect_dest_x <= base_dx + ni;
                  p2_rect_dest_y <= base_dy + nj;
                  p2_rect_src_x  <= base_sx + ni;
                  p2_rect_src_y  <= base_sy + nj;
               end
            end
            LINE: begin
               if (l_last) begin
                  state       <= IDLE;
                  busy        <= 1'b0;
                  p2_run_line <= 1'b0;
                  done        <= 1'b1;
               end else begin
                  p2_line_x <= nx;
                  p2_line_y <= ny;
                  err       <= nerr;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
